// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out deserializer.
// Holds default parameters and the bit-counter width function.
package sipo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LSB_FIRST = 0;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready holding buffer for assembled words.
// Ports: clk, reset, load/load_data in, word_data/word_valid out,
// word_ready in, drop out (a load arrived while full and not draining).
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             drop
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_room;

  // Room exists when empty or when the held word leaves this cycle.
  assign w_room = ~r_valid | word_ready;
  assign drop   = load & ~w_room;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load && w_room) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && word_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign word_data  = r_data;
  assign word_valid = r_valid;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with sync realignment and overrun flag.
// Ports: clk, reset, bit_valid, bit_in, sync in; word_data, word_valid,
// overrun, bit_count out; word_ready, clr_overrun in.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LSB_FIRST = DEF_LSB_FIRST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bit_valid,
  input  logic                      bit_in,
  input  logic                      sync,
  output logic [WIDTH-1:0]          word_data,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      overrun,
  input  logic                      clr_overrun,
  output logic [cnt_w(WIDTH)-1:0]   bit_count
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_overrun;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_seed;
  logic             w_last;
  logic             w_drop;

  assign w_shift = (LSB_FIRST != 0) ?
                   {bit_in, r_shreg[WIDTH-1:1]} :
                   {r_shreg[WIDTH-2:0], bit_in};

  // After sync the new first bit sits where later shifts expect it.
  assign w_seed = (LSB_FIRST != 0) ?
                  {bit_in, {(WIDTH-1){1'b0}}} :
                  {{(WIDTH-1){1'b0}}, bit_in};

  // sync outranks completion, so a realigning bit never emits a word.
  assign w_last = bit_valid & ~sync &
                  (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (sync) begin
      r_shreg <= bit_valid ? w_seed : '0;
      r_cnt   <= bit_valid ? CW'(1) : '0;
    end else if (bit_valid) begin
      r_shreg <= w_shift;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // A fresh drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (w_last),
    .load_data (w_shift),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .drop      (w_drop)
  );

  assign overrun   = r_overrun;
  assign bit_count = r_cnt;

endmodule
